// File: rtl/rtc_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : rtc_bus_bridge
// Description : PicoBlaze port-mapped bridge to a multiplexed address/data
//               RTC bus. Processor port writes launch timed bus cycles
//               (address phase, then data phase). Read data and status are
//               returned on in_port. An optional transfer-complete interrupt
//               is provided.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_bridge #(
  parameter logic [7:0]  PORT_ADDR   = 8'h01,
  parameter logic [7:0]  PORT_WDATA  = 8'h02,
  parameter logic [7:0]  PORT_CMD    = 8'h03,
  parameter logic [7:0]  PORT_STATUS = 8'h04,
  parameter logic [7:0]  PORT_RDATA  = 8'h05,
  // Phase lengths in clk cycles. Each must be at least 1 and at most 256.
  parameter int unsigned T_SETUP     = 2,
  parameter int unsigned T_PULSE     = 4,
  parameter int unsigned T_HOLD      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       read_strobe,
  input  logic       interrupt_ack,
  output logic [7:0] in_port,
  output logic       interrupt,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_sel
);

  // Down-counter reload values: a phase of N cycles counts N-1 .. 0.
  localparam logic [7:0] c_setup_ld = 8'(T_SETUP - 1);
  localparam logic [7:0] c_pulse_ld = 8'(T_PULSE - 1);
  localparam logic [7:0] c_hold_ld  = 8'(T_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_A_SETUP = 3'd1,
    S_A_PULSE = 3'd2,
    S_A_HOLD  = 3'd3,
    S_D_SETUP = 3'd4,
    S_D_PULSE = 3'd5,
    S_D_HOLD  = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  // ---------------------------------------------------------------------------
  // State and register file
  // ---------------------------------------------------------------------------
  state_t     state_q,   state_d;
  logic [7:0] cnt_q,     cnt_d;
  logic [7:0] addr_q,    addr_d;
  logic [7:0] wdata_q,   wdata_d;
  logic [7:0] rdata_q,   rdata_d;
  logic       rd_mode_q, rd_mode_d;   // 1 = current transfer is a bus read
  logic       busy_q,    busy_d;
  logic       done_q,    done_d;
  logic       err_q,     err_d;
  logic       int_en_q,  int_en_d;
  logic       irq_q,     irq_d;

  // Registered bus / processor outputs
  logic [7:0] in_port_q, in_port_d;
  logic [7:0] ad_out_q,  ad_out_d;
  logic       ad_oe_q,   ad_oe_d;
  logic       cs_n_q,    cs_n_d;
  logic       rd_n_q,    rd_n_d;
  logic       wr_n_q,    wr_n_d;
  logic       ad_sel_q,  ad_sel_d;

  // Decode helpers
  logic       wr_addr, wr_wdata, wr_cmd;
  logic       start_wr, start_rd;
  logic       status_rd;
  logic       irq_set;
  logic       a_phase, d_phase;
  logic [7:0] status_byte;

  assign status_byte = {5'b00000, err_q, done_q, busy_q};

  // Port decode, register updates and transfer sequencing
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rd_mode_d = rd_mode_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    int_en_d  = int_en_q;
    irq_set   = 1'b0;

    wr_addr   = write_strobe && (port_id == PORT_ADDR);
    wr_wdata  = write_strobe && (port_id == PORT_WDATA);
    wr_cmd    = write_strobe && (port_id == PORT_CMD);
    status_rd = read_strobe  && (port_id == PORT_STATUS);

    start_wr  = wr_wdata && !busy_q;
    start_rd  = wr_cmd && out_port[0] && !busy_q;

    // Processor writes: accepted when idle, rejected (with err) when busy.
    // A command write that only touches int_en is always accepted.
    if (!busy_q) begin
      if (wr_addr)  addr_d   = out_port;
      if (wr_wdata) wdata_d  = out_port;
      if (wr_cmd)   int_en_d = out_port[1];
    end else begin
      if (wr_addr || wr_wdata)
        err_d = 1'b1;
      if (wr_cmd) begin
        if (out_port[0]) err_d    = 1'b1;
        else             int_en_d = out_port[1];
      end
    end

    // Reading status acknowledges a completed transfer.
    if (status_rd)
      done_d = 1'b0;

    if (start_wr || start_rd) begin
      busy_d    = 1'b1;
      done_d    = 1'b0;
      err_d     = 1'b0;
      rd_mode_d = start_rd;
      state_d   = S_A_SETUP;
      cnt_d     = c_setup_ld;
    end

    // Timed phase sequencing; each timed state exits when the counter hits 0.
    case (state_q)
      S_IDLE: ;
      S_A_SETUP: begin
        if (cnt_q == 8'd0) begin state_d = S_A_PULSE; cnt_d = c_pulse_ld; end
        else cnt_d = cnt_q - 8'd1;
      end
      S_A_PULSE: begin
        if (cnt_q == 8'd0) begin state_d = S_A_HOLD; cnt_d = c_hold_ld; end
        else cnt_d = cnt_q - 8'd1;
      end
      S_A_HOLD: begin
        if (cnt_q == 8'd0) begin state_d = S_D_SETUP; cnt_d = c_setup_ld; end
        else cnt_d = cnt_q - 8'd1;
      end
      S_D_SETUP: begin
        if (cnt_q == 8'd0) begin state_d = S_D_PULSE; cnt_d = c_pulse_ld; end
        else cnt_d = cnt_q - 8'd1;
      end
      S_D_PULSE: begin
        if (cnt_q == 8'd0) begin
          // Capture the pad while rd_n is still low, on its final cycle.
          if (rd_mode_q) rdata_d = ad_in;
          state_d = S_D_HOLD;
          cnt_d   = c_hold_ld;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_D_HOLD: begin
        if (cnt_q == 8'd0) begin state_d = S_DONE; cnt_d = 8'd0; end
        else cnt_d = cnt_q - 8'd1;
      end
      S_DONE: begin
        // Completion wins over a coincident status read clearing done.
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        irq_set = int_en_q;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Interrupt: acknowledge clears, but a new completion on the same edge wins.
  always_comb begin
    irq_d = irq_q;
    if (interrupt_ack) irq_d = 1'b0;
    if (irq_set)       irq_d = 1'b1;
  end

  // Bus outputs derived from the next state so the registered pins line up
  // with the state register and never glitch.
  always_comb begin
    a_phase  = (state_d == S_A_SETUP) || (state_d == S_A_PULSE) || (state_d == S_A_HOLD);
    d_phase  = (state_d == S_D_SETUP) || (state_d == S_D_PULSE) || (state_d == S_D_HOLD);

    cs_n_d   = (state_d == S_IDLE);
    ad_sel_d = d_phase || (state_d == S_DONE);
    ad_oe_d  = a_phase || (d_phase && !rd_mode_d);
    wr_n_d   = !((state_d == S_A_PULSE) || ((state_d == S_D_PULSE) && !rd_mode_d));
    rd_n_d   = !((state_d == S_D_PULSE) && rd_mode_d);

    ad_out_d = 8'h00;
    if (a_phase)                    ad_out_d = addr_d;
    else if (d_phase && !rd_mode_d) ad_out_d = wdata_d;
  end

  // Processor read mux, registered for one-cycle latency off port_id.
  always_comb begin
    in_port_d = 8'h00;
    if (port_id == PORT_STATUS)     in_port_d = status_byte;
    else if (port_id == PORT_RDATA) in_port_d = rdata_q;
  end

  // State, register file and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      rd_mode_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      int_en_q  <= 1'b0;
      irq_q     <= 1'b0;
      in_port_q <= 8'h00;
      ad_out_q  <= 8'h00;
      ad_oe_q   <= 1'b0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      ad_sel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rd_mode_q <= rd_mode_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      int_en_q  <= int_en_d;
      irq_q     <= irq_d;
      in_port_q <= in_port_d;
      ad_out_q  <= ad_out_d;
      ad_oe_q   <= ad_oe_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      ad_sel_q  <= ad_sel_d;
    end
  end

  assign in_port   = in_port_q;
  assign interrupt = irq_q;
  assign ad_out    = ad_out_q;
  assign ad_oe     = ad_oe_q;
  assign cs_n      = cs_n_q;
  assign rd_n      = rd_n_q;
  assign wr_n      = wr_n_q;
  assign ad_sel    = ad_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_rtc_bus_bridge
// Description : Self-checking bench for rtc_bus_bridge. Bus transfers are
//               scored by a pin monitor against an expected-transfer queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_bridge;

  localparam logic [7:0] P_ADDR   = 8'h01;
  localparam logic [7:0] P_WDATA  = 8'h02;
  localparam logic [7:0] P_CMD    = 8'h03;
  localparam logic [7:0] P_STATUS = 8'h04;
  localparam logic [7:0] P_RDATA  = 8'h05;
  localparam int T_S = 2;
  localparam int T_P = 4;
  localparam int T_H = 2;
  localparam int XFER_LEN = 2 * (T_S + T_P + T_H) + 1;

  typedef struct {
    logic       is_rd;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] port_id = 8'h00;
  logic [7:0] out_port = 8'h00;
  logic       write_strobe = 1'b0;
  logic       read_strobe = 1'b0;
  logic       interrupt_ack = 1'b0;
  logic [7:0] in_port;
  logic       interrupt;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] ad_in;
  logic       cs_n, rd_n, wr_n, ad_sel;
  logic [7:0] rd_pad_val = 8'h00;

  int vectors = 0;
  int miscompares = 0;
  exp_t exp_q[$];

  // RTC model: presents data only while it sees rd_n low.
  assign ad_in = rd_n ? 8'hEE : rd_pad_val;

  always #5 clk = ~clk;

  rtc_bus_bridge dut (
    .clk(clk), .rst(rst), .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .read_strobe(read_strobe),
    .interrupt_ack(interrupt_ack), .in_port(in_port), .interrupt(interrupt),
    .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in), .cs_n(cs_n),
    .rd_n(rd_n), .wr_n(wr_n), .ad_sel(ad_sel)
  );

  // Pin monitor and scoreboard: measures each cs_n-low window and compares it
  // with the next expected transfer.
  initial begin : monitor
    bit in_xfer;
    int cs_cnt, a_wr, a_rd, d_wr, d_rd, d_oe;
    logic a_bad_oe, a_ok, d_ok, a_seen, d_seen;
    logic [7:0] a_val, d_val;
    exp_t e;
    in_xfer = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_xfer = 0;
      end else if (!cs_n) begin
        if (!in_xfer) begin
          in_xfer = 1; cs_cnt = 0; a_wr = 0; a_rd = 0; d_wr = 0; d_rd = 0; d_oe = 0;
          a_bad_oe = 0; a_ok = 1; d_ok = 1; a_seen = 0; d_seen = 0; a_val = 0; d_val = 0;
        end
        cs_cnt++;
        if (!ad_sel) begin
          if (!ad_oe) a_bad_oe = 1;
          if (!a_seen) begin a_val = ad_out; a_seen = 1; end
          else if (ad_out !== a_val) a_ok = 0;
          if (!wr_n) a_wr++;
          if (!rd_n) a_rd++;
        end else begin
          if (!wr_n) d_wr++;
          if (!rd_n) d_rd++;
          if (ad_oe) begin
            d_oe++;
            if (!d_seen) begin d_val = ad_out; d_seen = 1; end
            else if (ad_out !== d_val) d_ok = 0;
          end
        end
      end else if (in_xfer) begin
        in_xfer = 0;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL xfer_unexpected: got a bus transfer, required none");
        end else begin
          e = exp_q.pop_front();
          vectors++;
          if (cs_cnt != XFER_LEN) begin
            miscompares++;
            $display("FAIL xfer_cs_len: got %0d cycles, required %0d", cs_cnt, XFER_LEN);
          end
          vectors++;
          if (a_val !== e.addr || !a_ok || a_bad_oe) begin
            miscompares++;
            $display("FAIL xfer_addr: got %02h (stable=%0b oe_dropped=%0b), required %02h stable",
                     a_val, a_ok, a_bad_oe, e.addr);
          end
          vectors++;
          if (a_wr != T_P || a_rd != 0) begin
            miscompares++;
            $display("FAIL xfer_addr_strobe: got wr_n low %0d rd_n low %0d, required %0d and 0",
                     a_wr, a_rd, T_P);
          end
          vectors++;
          if (e.is_rd) begin
            if (d_rd != T_P || d_wr != 0 || d_oe != 0) begin
              miscompares++;
              $display("FAIL xfer_rd_phase: got rd_n low %0d wr_n low %0d oe %0d, required %0d 0 0",
                       d_rd, d_wr, d_oe, T_P);
            end
          end else begin
            if (d_wr != T_P || d_rd != 0 || d_oe != T_S + T_P + T_H || d_val !== e.data || !d_ok) begin
              miscompares++;
              $display("FAIL xfer_wr_phase: got wr_n low %0d rd_n low %0d oe %0d data %02h stable %0b, required %0d 0 %0d %02h 1",
                       d_wr, d_rd, d_oe, d_val, d_ok, T_P, T_S + T_P + T_H, e.data);
            end
          end
        end
      end
    end
  end

  task automatic wr_port(input logic [7:0] id, input logic [7:0] d);
    @(negedge clk);
    port_id = id; out_port = d; write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0; port_id = 8'h00; out_port = 8'h00;
  endtask

  task automatic rd_port(input logic [7:0] id, output logic [7:0] d);
    @(negedge clk);
    port_id = id; read_strobe = 1'b1;
    @(negedge clk);
    d = in_port;
    read_strobe = 1'b0; port_id = 8'h00;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_timeout: %0d transfers outstanding, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    logic [7:0] s;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cs_n, rd_n, wr_n, ad_oe, ad_sel, interrupt} !== 6'b111000 || ad_out !== 8'h00 || in_port !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_pins: got cs/rd/wr/oe/sel/irq=%b%b%b%b%b%b ad_out=%02h in_port=%02h, required 111000 00 00",
               cs_n, rd_n, wr_n, ad_oe, ad_sel, interrupt, ad_out, in_port);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({cs_n, rd_n, wr_n, ad_oe, interrupt} !== 5'b11100) begin
      miscompares++;
      $display("FAIL idle_pins: got cs/rd/wr/oe/irq=%b%b%b%b%b, required 11100", cs_n, rd_n, wr_n, ad_oe, interrupt);
    end
    rd_port(P_STATUS, s);
    vectors++;
    if (s !== 8'h00) begin miscompares++; $display("FAIL reset_status: got %02h, required 00", s); end
    rd_port(P_RDATA, s);
    vectors++;
    if (s !== 8'h00) begin miscompares++; $display("FAIL reset_rdata: got %02h, required 00", s); end
    // Unmapped write and a non-start command must not launch anything.
    wr_port(8'h07, 8'hFF);
    wr_port(P_CMD, 8'h00);
    repeat (3) @(negedge clk);
    rd_port(P_STATUS, s);
    vectors++;
    if (s !== 8'h00 || cs_n !== 1'b1) begin
      miscompares++;
      $display("FAIL unmapped_write: got status %02h cs_n %b, required 00 1", s, cs_n);
    end
  endtask

  task automatic test_write();
    logic [7:0] s;
    wr_port(P_ADDR, 8'h21);
    exp_q.push_back('{1'b0, 8'h21, 8'h5A});
    wr_port(P_WDATA, 8'h5A);
    rd_port(P_STATUS, s);
    vectors++;
    if (s !== 8'h01) begin miscompares++; $display("FAIL write_busy: got %02h, required 01", s); end
    wait_drain("write");
    rd_port(P_STATUS, s);
    vectors++;
    if (s !== 8'h02) begin miscompares++; $display("FAIL write_done: got %02h, required 02", s); end
    rd_port(P_STATUS, s);
    vectors++;
    if (s !== 8'h00 || interrupt !== 1'b0) begin
      miscompares++;
      $display("FAIL write_done_clear: got status %02h irq %b, required 00 0", s, interrupt);
    end
  endtask

  task automatic test_read();
    logic [7:0] s;
    rd_pad_val = 8'h37;
    wr_port(P_ADDR, 8'h22);
    exp_q.push_back('{1'b1, 8'h22, 8'h37});
    wr_port(P_CMD, 8'h03);
    wait_drain("read");
    vectors++;
    if (interrupt !== 1'b1) begin miscompares++; $display("FAIL read_irq_rise: got %b, required 1", interrupt); end
    repeat (3) @(negedge clk);
    vectors++;
    if (interrupt !== 1'b1) begin miscompares++; $display("FAIL read_irq_hold: got %b, required 1", interrupt); end
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    vectors++;
    if (interrupt !== 1'b0) begin miscompares++; $display("FAIL read_irq_ack: got %b, required 0", interrupt); end
    rd_port(P_RDATA, s);
    vectors++;
    if (s !== 8'h37) begin miscompares++; $display("FAIL read_rdata: got %02h, required 37", s); end
    rd_port(P_STATUS, s);
    vectors++;
    if (s !== 8'h02) begin miscompares++; $display("FAIL read_status: got %02h, required 02", s); end
    wr_port(P_CMD, 8'h00);
  endtask

  task automatic test_busy_error();
    logic [7:0] s;
    wr_port(P_ADDR, 8'h30);
    exp_q.push_back('{1'b0, 8'h30, 8'hA5});
    wr_port(P_WDATA, 8'hA5);
    wr_port(P_WDATA, 8'hFF);
    wr_port(P_ADDR, 8'h77);
    wr_port(P_CMD, 8'h02);
    wr_port(P_CMD, 8'h01);
    wait_drain("busy_err");
    rd_port(P_STATUS, s);
    vectors++;
    if (s !== 8'h06) begin miscompares++; $display("FAIL busy_err_status: got %02h, required 06", s); end
    vectors++;
    if (interrupt !== 1'b1) begin miscompares++; $display("FAIL busy_int_en: got %b, required 1", interrupt); end
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    wr_port(P_CMD, 8'h00);
    exp_q.push_back('{1'b0, 8'h30, 8'h11});
    wr_port(P_WDATA, 8'h11);
    rd_port(P_STATUS, s);
    vectors++;
    if (s !== 8'h01) begin miscompares++; $display("FAIL busy_err_clear: got %02h, required 01", s); end
    wait_drain("err_clear");
    rd_port(P_STATUS, s);
    vectors++;
    if (s !== 8'h02 || interrupt !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear_done: got status %02h irq %b, required 02 0", s, interrupt);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] s;
    bit found;
    found = 0;
    wr_port(P_ADDR, 8'h40);
    wr_port(P_WDATA, 8'h99);
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (!wr_n && ad_sel) found = 1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL rst_mid_reach: got no data strobe, required one"); end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({cs_n, rd_n, wr_n, ad_oe, ad_sel} !== 5'b11100) begin
      miscompares++;
      $display("FAIL rst_mid_pins: got cs/rd/wr/oe/sel=%b%b%b%b%b, required 11100", cs_n, rd_n, wr_n, ad_oe, ad_sel);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd_port(P_STATUS, s);
    vectors++;
    if (s !== 8'h00) begin miscompares++; $display("FAIL rst_mid_status: got %02h, required 00", s); end
    wr_port(P_ADDR, 8'h41);
    exp_q.push_back('{1'b0, 8'h41, 8'h3C});
    wr_port(P_WDATA, 8'h3C);
    wait_drain("rst_recover");
    rd_port(P_STATUS, s);
    vectors++;
    if (s !== 8'h02) begin miscompares++; $display("FAIL rst_recover_status: got %02h, required 02", s); end
  endtask

  task automatic test_back_to_back();
    wr_port(P_CMD, 8'h02);
    wr_port(P_ADDR, 8'h50);
    exp_q.push_back('{1'b0, 8'h50, 8'h01});
    wr_port(P_WDATA, 8'h01);
    wait_drain("b2b_first");
    vectors++;
    if (interrupt !== 1'b1) begin miscompares++; $display("FAIL b2b_irq_first: got %b, required 1", interrupt); end
    exp_q.push_back('{1'b0, 8'h50, 8'h02});
    wr_port(P_WDATA, 8'h02);
    // Line up interrupt_ack with the DONE cycle of this transfer.
    repeat (XFER_LEN - 1) @(negedge clk);
    vectors++;
    if (cs_n !== 1'b0) begin miscompares++; $display("FAIL b2b_done_align: got cs_n %b, required 0", cs_n); end
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    vectors++;
    if (cs_n !== 1'b1 || interrupt !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ack_vs_done: got cs_n %b irq %b, required 1 1", cs_n, interrupt);
    end
    wait_drain("b2b_second");
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    vectors++;
    if (interrupt !== 1'b0) begin miscompares++; $display("FAIL b2b_final_ack: got %b, required 0", interrupt); end
    wr_port(P_CMD, 8'h00);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_busy_error();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/rtc_bus_bridge.md
Name: rtc_bus_bridge

Overview:
- Port-mapped peripheral directly downstream of the PicoBlaze processor wrapper.
- Consumes port_id, out_port, write_strobe, read_strobe and interrupt_ack; produces in_port and interrupt.
- Converts processor port writes into timed multiplexed address/data bus cycles to an external RTC chip.
- Returns read data and status through the processor input port.

Parameters:
- PORT_ADDR, 8'h01, write: latch RTC register address
- PORT_WDATA, 8'h02, write: latch data and start a bus write cycle
- PORT_CMD, 8'h03, write: bit0=1 starts a bus read cycle; bit1 is the interrupt enable (stored)
- PORT_STATUS, 8'h04, read: {5'b0, err, done, busy}
- PORT_RDATA, 8'h05, read: last data captured from the RTC
- T_SETUP, 2, cycles the bus is stable before a strobe
- T_PULSE, 4, strobe low width in cycles (≥1)
- T_HOLD, 2, cycles the bus is held after a strobe

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- port_id  input  8  processor port address
- out_port  input  8  processor write data
- write_strobe  input  1  processor write qualifier
- read_strobe  input  1  processor read qualifier
- interrupt_ack  input  1  processor interrupt acknowledge
- in_port  output  8  read data to processor
- interrupt  output  1  transfer-complete interrupt
- ad_out  output  8  multiplexed address/data driven to the RTC
- ad_oe  output  1  1 = drive ad_out onto the pad (tristate lives at top level)
- ad_in  input  8  pad data from the RTC
- cs_n  output  1  chip select, active low
- rd_n  output  1  read strobe, active low
- wr_n  output  1  write strobe, active low
- ad_sel  output  1  0 = address phase, 1 = data phase

Behaviour:
- Reset (async, rst=1) values:
  - in_port=0, interrupt=0, ad_out=0, ad_oe=0
  - cs_n=1, rd_n=1, wr_n=1, ad_sel=0
  - addr, wdata, rdata registers = 0
  - busy=0, done=0, err=0, int_en=0
  - FSM in IDLE, counter=0
- Reset mid-transfer aborts immediately. Strobes return high in the same reset assertion, with no partial cycle completion.
- Port writes are sampled only on a clk edge where write_strobe=1. port_id is decoded exactly; unmapped writes are ignored.
- When not busy:
  - PORT_ADDR write loads addr.
  - PORT_WDATA write loads wdata and starts a write cycle.
  - PORT_CMD write loads int_en=out_port[1]. If out_port[0]=1, it also starts a read cycle.
- A start does the following: busy←1, done←0, err←0, FSM leaves IDLE on the next edge.
- Writes to PORT_WDATA, or to PORT_CMD with bit0=1, while busy:
  - are ignored and set err=1;
  - leave the transfer unaffected.
- PORT_ADDR writes while busy are also ignored and set err=1.
- A PORT_CMD write with bit0=0 while busy updates int_en only.
- FSM states: IDLE → A_SETUP → A_PULSE → A_HOLD → D_SETUP → D_PULSE → D_HOLD → DONE → IDLE.
  - Each of the *_SETUP, *_PULSE and *_HOLD states lasts exactly T_SETUP, T_PULSE and T_HOLD cycles respectively, using an 8-bit down counter.
  - DONE lasts 1 cycle.
- cs_n=0 in every state except IDLE.
- A_* states: ad_sel=0, ad_oe=1, ad_out=addr. wr_n=0 only in A_PULSE.
- D_* states for a write: ad_sel=1, ad_oe=1, ad_out=wdata. wr_n=0 only in D_PULSE.
- D_* states for a read: ad_sel=1, ad_oe=0, rd_n=0 only in D_PULSE. rdata←ad_in on the last cycle of D_PULSE.
- All bus outputs are registered (glitch-free strobes).
- DONE: busy←0, done←1. If int_en=1, interrupt←1.
- interrupt stays high until a cycle with interrupt_ack=1, which clears it.
  - If ack and a new DONE coincide, interrupt stays 1.
- done is sticky. It is cleared by the next start or by a read of PORT_STATUS (read_strobe=1 with port_id=PORT_STATUS).
- in_port is registered every cycle from port_id: STATUS, RDATA, else 8'h00. This gives 1-cycle latency, valid within the processor's 2-cycle port_id window.
- Total transfer length = 2·(T_SETUP+T_PULSE+T_HOLD)+1 cycles from the first non-IDLE state to the return to IDLE. With defaults this is 17.

Test Plan:
- Reset released, no stimulus → cs_n=rd_n=wr_n=1, ad_oe=0, interrupt=0, reading PORT_STATUS returns 8'h00.
- Write PORT_ADDR=8'h21, then PORT_WDATA=8'h5A → the bus shows the address phase with ad_out=8'h21 and wr_n low for exactly 4 cycles. The data phase follows with ad_out=8'h5A and wr_n low for 4 cycles. busy is high for 17 cycles, then STATUS=8'h02.
- PORT_CMD=8'h03 (read, int_en) with addr=8'h22, and the bench drives ad_in=8'h37 during D_PULSE → ad_oe=0 in the data phase, rd_n low for 4 cycles, PORT_RDATA reads 8'h37, interrupt rises in DONE and stays high until interrupt_ack, then clears.
- PORT_WDATA write while busy → the transfer completes with its original data, STATUS reads 8'h06 (err and done set), and the next start clears err.
- Assert rst during D_PULSE of a write → all strobes are immediately 1, cs_n=1, busy=0, and a subsequent transfer runs normally.
- interrupt_ack coinciding with a second transfer's DONE (int_en=1) → interrupt remains 1 afterwards.
